tt_sweep_ctrl: RTL and testbench

Sequencer for the lab's 4-input combinational function units (f = F(a,b,c,d)). On a start request it drives all 16 input vectors, in ascending binary order, into an externally attached function unit. It samples f for each vector and assembles the result into a 16-bit truth-table register, then signals completion. It replaces hand-written exhaustive stimulus sequences with a reusable on-chip characterisation controller.

---
 rtl/tt_sweep_pkg.sv | 7 +
 rtl/tt_dwell_timer.sv | 19 +
 rtl/tt_sweep_ctrl.sv | 63 ++++++
 tb/tb_tt_sweep_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared states and sizes for the truth-table sweep controller
package tt_sweep_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  localparam int VEC_W = 4;
  localparam int NUM_VEC = 16;
  localparam int DWELL_DEF = 1;
endpackage

// File: rtl/tt_dwell_timer.sv
// tt_dwell_timer: 8-bit dwell counter, tc flags the last cycle of a vector's dwell
module tt_dwell_timer
  import tt_sweep_pkg::*;
#(
  parameter int DWELL = DWELL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam logic [7:0] LAST = 8'(DWELL - 1);
  logic [7:0] cnt;
  assign tc = cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : en ? (tc ? '0 : cnt + 8'd1) : cnt;
endmodule

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: drives all 16 vectors into an external unit and captures its truth table
// MINTERM_COUNT_EN adds the ones port with a running count of 1s in tt.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int DWELL = DWELL_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               f,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  output logic               busy,
  output logic               done,
  output logic [VEC_W-1:0]   idx,
  output logic [NUM_VEC-1:0] tt
`ifdef MINTERM_COUNT_EN
  ,
  output logic [4:0]         ones
`endif
);
  state_t state, state_d;
  logic [VEC_W-1:0] vec;
  logic tc, accept, sample, last;
  tt_dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state != DRIVE),
    .en   (state == DRIVE),
    .tc   (tc)
  );
  always_comb begin
    accept = state == IDLE && start && !abort;
    sample = state == DRIVE && tc && !abort;
    last = vec == VEC_W'(NUM_VEC - 1);
    state_d = abort ? IDLE : accept ? DRIVE : (sample && last) ? DONE : state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      vec <= '0;
      tt <= '0;
    end else begin
      state <= state_d;
      vec <= (accept || state_d == IDLE) ? '0 : (sample && !last) ? vec + 1'b1 : vec;
      if (accept) tt <= '0;
      else if (sample) tt[vec] <= f;
    end
`ifdef MINTERM_COUNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ones <= '0;
    else if (accept) ones <= '0;
    else if (sample) ones <= ones + 5'(f);
`endif
  assign {a, b, c, d} = vec;
  assign idx = vec;
  assign busy = state == DRIVE;
  assign done = state == DONE;
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb_tt_sweep_ctrl: random truth tables swept on DWELL=1 and DWELL=3 instances
module tb_tt_sweep_ctrl;
  logic clk = 0, rst_n = 0;
  logic start1 = 0, abort1 = 0, start3 = 0, abort3 = 0;
  logic a1, b1, c1, d1, busy1, done1, a3, b3, c3, d3, busy3, done3;
  logic [3:0] idx1, idx3;
  logic [15:0] tt1, tt3, lut1 = 0, lut3 = 0;
  logic f1, f3, sel = 0;
  logic [4:0] ones1, ones3;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  assign f1 = lut1[{a1, b1, c1, d1}];
  assign f3 = lut3[{a3, b3, c3, d3}];
`ifndef MINTERM_COUNT_EN
  assign ones1 = 5'($countones(tt1));
  assign ones3 = 5'($countones(tt3));
`endif
  tt_sweep_ctrl #(.DWELL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .f(f1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .idx(idx1), .tt(tt1)
`ifdef MINTERM_COUNT_EN
    , .ones(ones1)
`endif
  );
  tt_sweep_ctrl #(.DWELL(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .f(f3),
    .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3), .idx(idx3), .tt(tt3)
`ifdef MINTERM_COUNT_EN
    , .ones(ones3)
`endif
  );
  logic busy_s, done_s;
  logic [3:0] idx_s, vec_s;
  logic [15:0] tt_s;
  logic [4:0] ones_s;
  assign busy_s = sel ? busy3 : busy1;
  assign done_s = sel ? done3 : done1;
  assign idx_s = sel ? idx3 : idx1;
  assign vec_s = sel ? {a3, b3, c3, d3} : {a1, b1, c1, d1};
  assign tt_s = sel ? tt3 : tt1;
  assign ones_s = sel ? ones3 : ones1;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    nvec++;
    assert (obs === want) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask
  task automatic drive_start(input logic v);
    if (sel) start3 = v;
    else start1 = v;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 16'(busy_s), 16'd0);
    chk({tag, "_done"}, 16'(done_s), 16'd0);
    chk({tag, "_idx"}, 16'(idx_s), 16'd0);
    chk({tag, "_abcd"}, 16'(vec_s), 16'd0);
  endtask
  // Called at the falling edge right after the accepting edge; ends in the done cycle.
  task automatic watch(input logic [15:0] want_tt, input int dw, input bit poke);
    for (int j = 0; j < 16 * dw; j++) begin
      if (j == 0) chk("tt_cleared", tt_s, 16'd0);
      chk("busy", 16'(busy_s), 16'd1);
      chk("done_early", 16'(done_s), 16'd0);
      chk("idx", 16'(idx_s), 16'(j / dw));
      chk("abcd", 16'(vec_s), 16'(j / dw));
      if (poke && j == 3) drive_start(1);
      if (poke && j == 4) drive_start(0);
      @(negedge clk);
    end
    chk("done", 16'(done_s), 16'd1);
    chk("busy_end", 16'(busy_s), 16'd0);
    chk("idx_end", 16'(idx_s), 16'd15);
    chk("tt", tt_s, want_tt);
    chk("ones", 16'(ones_s), 16'($countones(want_tt)));
  endtask
  task automatic sweep(input bit s, input logic [15:0] want_tt, input int dw);
    sel = s;
    drive_start(1);
    @(negedge clk);
    drive_start(0);
    watch(want_tt, dw, 0);
    @(negedge clk);
    chk_idle("post");
    chk("tt_hold", tt_s, want_tt);
  endtask
  initial begin
    logic [15:0] r, r2;
    logic [3:0] p;
    #12;
    sel = 0;
    chk_idle("rst1");
    chk("rst1_tt", tt_s, 16'd0);
    chk("rst1_ones", 16'(ones_s), 16'd0);
    sel = 1;
    chk_idle("rst3");
    chk("rst3_tt", tt_s, 16'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    for (int v = 0; v < 16; v++) begin
      p = 4'(v);
      lut1[v] = ^p;
      lut3[v] = &p;
    end
    sweep(0, 16'h6996, 1);
    sweep(1, 16'h8000, 3);
    repeat (4) begin
      lut1 = 16'($urandom());
      sweep(0, lut1, 1);
    end
    repeat (2) begin
      lut3 = 16'($urandom());
      sweep(1, lut3, 3);
    end
    sel = 0;
    lut1 = 16'hffff;
    drive_start(1);
    @(negedge clk);
    drive_start(0);
    repeat (5) @(negedge clk);
    chk("abort_at", 16'(idx_s), 16'd5);
    abort1 = 1;
    @(negedge clk);
    abort1 = 0;
    chk_idle("abort");
    chk("abort_tt", tt_s, 16'h001f);
    chk("abort_ones", 16'(ones_s), 16'd5);
    repeat (3) begin
      @(negedge clk);
      chk("abort_nodone", 16'(done_s), 16'd0);
      chk("abort_nobusy", 16'(busy_s), 16'd0);
    end
    r = 16'($urandom());
    lut1 = r;
    drive_start(1);
    @(negedge clk);
    drive_start(0);
    watch(r, 1, 1);
    drive_start(1);
    @(negedge clk);
    drive_start(0);
    chk_idle("ign_done");
    chk("ign_tt", tt_s, r);
    @(negedge clk);
    chk_idle("ign_after");
    r = 16'($urandom()) | 16'h0001;
    r2 = 16'($urandom());
    lut1 = r;
    drive_start(1);
    @(negedge clk);
    watch(r, 1, 0);
    @(negedge clk);
    chk_idle("b2b_gap");
    lut1 = r2;
    @(negedge clk);
    drive_start(0);
    watch(r2, 1, 0);
    @(negedge clk);
    chk_idle("b2b_post");
    lut1 = 16'($urandom()) | 16'h0001;
    drive_start(1);
    @(negedge clk);
    drive_start(0);
    repeat (9) @(negedge clk);
    chk("rst_at", 16'(idx_s), 16'd9);
    #2 rst_n = 0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_tt", tt_s, 16'd0);
    chk("async_rst_ones", 16'(ones_s), 16'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk_idle("after_rst");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
